// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch sequencer. Owns the PC, drives imem req/ack,
// loads IF/ID, and applies redirects, load-use stalls and flushes.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   ex_mem_pcsrc/npc  branch redirect request and target
//   hazard_stall      ID load-use stall, IF/ID must hold
//   imem_ack/rdata    memory response (data valid with ack)
//   imem_req/addr     outstanding request and its address
//   pc                architectural PC register
//   if_id_*           IF/ID pipeline register (instr, next PC, valid)
//   timeout_err       sticky unanswered-request flag
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'h0000_0001,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mem_pcsrc,
  input  logic [31:0] ex_mem_npc,
  input  logic        hazard_stall,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_npc,
  output logic        if_id_valid,
  output logic        timeout_err
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STALL,
    DRAIN
  } state_t;

  state_t      state;
  logic [31:0] req_addr;
  logic [31:0] step_addr;
  logic [31:0] skid_instr;
  logic [31:0] skid_npc;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_nxt;

  // imem_req is the only output decoded from state so that a
  // zero-wait memory can ack in the same cycle the request rises.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = req_addr;
  assign step_addr = req_addr + PC_STEP;

  // Counts consecutive unanswered request cycles, saturating.
  // Any cycle without an outstanding request (IDLE/STALL) clears it.
  always_comb begin
    wait_nxt = '0;
    if (imem_req && !imem_ack) begin
      if (wait_cnt == 8'hFF) begin
        wait_nxt = wait_cnt;
      end else begin
        wait_nxt = wait_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_npc   <= '0;
      if_id_valid <= 1'b0;
      skid_instr  <= NOP_INSTR;
      skid_npc    <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (wait_nxt == TO_LIMIT) begin
        timeout_err <= 1'b1;
      end

      if (ex_mem_pcsrc) begin
        pc          <= ex_mem_npc;
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
        skid_instr  <= NOP_INSTR;
        skid_npc    <= '0;
        // An unanswered request cannot be withdrawn, so its
        // response is drained first. Once the old request is
        // answered (or none is pending) fetch goes straight
        // to the target, including an ack arriving in DRAIN.
        if (imem_req && !imem_ack) begin
          state <= DRAIN;
        end else begin
          req_addr <= ex_mem_npc;
          state    <= FETCH;
        end
      end else begin
        unique case (state)
          IDLE: begin
            req_addr <= pc;
            state    <= FETCH;
          end

          FETCH: begin
            if (imem_ack) begin
              if (hazard_stall) begin
                // Park the word; IF/ID is held by ID.
                skid_instr <= imem_rdata;
                skid_npc   <= step_addr;
                state      <= STALL;
              end else begin
                if_id_instr <= imem_rdata;
                if_id_npc   <= step_addr;
                if_id_valid <= 1'b1;
                pc          <= step_addr;
                req_addr    <= step_addr;
              end
            end else if (!hazard_stall) begin
              if_id_instr <= NOP_INSTR;
              if_id_valid <= 1'b0;
            end
          end

          STALL: begin
            if (!hazard_stall) begin
              if_id_instr <= skid_instr;
              if_id_npc   <= skid_npc;
              if_id_valid <= 1'b1;
              pc          <= skid_npc;
              req_addr    <= skid_npc;
              state       <= FETCH;
            end
          end

          DRAIN: begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if (imem_ack) begin
              req_addr <= pc;
              state    <= FETCH;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: vector table, timeout/reset sequence and a random
// run against a transaction-level reference model of fetch_ctrl.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_mem_pcsrc;
  logic [31:0] ex_mem_npc;
  logic        hazard_stall;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  logic        timeout_err;

  fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_mem_pcsrc (ex_mem_pcsrc),
    .ex_mem_npc   (ex_mem_npc),
    .hazard_stall (hazard_stall),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .if_id_instr  (if_id_instr),
    .if_id_npc    (if_id_npc),
    .if_id_valid  (if_id_valid),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] npc;
  } vec_t;

  vec_t vq[$];

  task automatic row(
    input logic r, input logic ps, input logic [31:0] tg,
    input logic st, input logic ak, input logic [31:0] rd,
    input logic rq, input logic [31:0] ad, input logic [31:0] p,
    input logic v, input logic [31:0] ins, input logic [31:0] np);
    vec_t x;
    x.rst_n = r;  x.pcsrc = ps; x.tgt = tg;
    x.stall = st; x.ack = ak;   x.rdata = rd;
    x.req = rq;   x.addr = ad;  x.pc = p;
    x.valid = v;  x.instr = ins; x.npc = np;
    vq.push_back(x);
  endtask

  task automatic drive(input logic r, input logic ps,
                       input logic [31:0] tg, input logic st,
                       input logic ak, input logic [31:0] rd);
    rst_n = r; ex_mem_pcsrc = ps; ex_mem_npc = tg;
    hazard_stall = st; imem_ack = ak; imem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: a request is either absent or outstanding
  // (possibly marked for discard); a stalled word sits in a holding
  // slot. IF/ID, pc and the request address are plain variables.
  logic        m_busy;
  logic        m_discard;
  logic        m_held;
  logic [31:0] m_hinstr;
  logic [31:0] m_hnpc;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_npc;
  int          m_wait;
  logic        m_err;

  task automatic model_step(input logic r, input logic ps,
                            input logic [31:0] tg, input logic st,
                            input logic ak, input logic [31:0] rd);
    int w;
    if (!r) begin
      m_busy = 0; m_discard = 0; m_held = 0;
      m_hinstr = 0; m_hnpc = 0; m_pc = 0; m_addr = 0;
      m_valid = 0; m_instr = 0; m_npc = 0;
      m_wait = 0; m_err = 0;
      return;
    end
    w = (m_busy && !ak) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
    m_wait = w;
    if (w == 255) m_err = 1;
    if (ps) begin
      m_pc = tg; m_valid = 0; m_instr = 0; m_held = 0;
      if (m_busy && !ak) begin
        m_discard = 1;
      end else begin
        m_addr = tg; m_busy = 1; m_discard = 0;
      end
    end else if (m_held) begin
      if (!st) begin
        m_instr = m_hinstr; m_npc = m_hnpc; m_valid = 1;
        m_pc = m_pc + 1; m_addr = m_addr + 1;
        m_held = 0; m_busy = 1;
      end
    end else if (!m_busy) begin
      m_busy = 1; m_addr = m_pc;
    end else if (m_discard) begin
      m_instr = 0; m_valid = 0;
      if (ak) begin
        m_discard = 0; m_addr = m_pc;
      end
    end else if (ak) begin
      if (st) begin
        m_hinstr = rd; m_hnpc = m_addr + 1;
        m_held = 1; m_busy = 0;
      end else begin
        m_instr = rd; m_npc = m_addr + 1; m_valid = 1;
        m_addr = m_addr + 1; m_pc = m_addr;
      end
    end else if (!st) begin
      m_instr = 0; m_valid = 0;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    drive(0, 0, 0, 0, 0, 0);

    // Timeout and reset sequence.
    tick();
    check("rst_req", 32'(imem_req), 0);
    check("rst_pc", pc, 0);
    check("rst_valid", 32'(if_id_valid), 0);
    check("rst_err", 32'(timeout_err), 0);
    rst_n = 1;
    tick();
    check("first_req", 32'(imem_req), 1);
    check("first_addr", imem_addr, 0);
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i == 254) check("to_early", 32'(timeout_err), 0);
      if (i == 255) check("to_set", 32'(timeout_err), 1);
    end
    check("to_addr", imem_addr, 0);
    drive(1, 0, 0, 0, 1, 32'h1234);
    tick();
    check("late_ack_err", 32'(timeout_err), 1);
    check("late_ack_instr", if_id_instr, 32'h1234);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    check("mid_req", 32'(imem_req), 1);
    rst_n = 0;
    tick();
    check("mid_rst_err", 32'(timeout_err), 0);
    check("mid_rst_req", 32'(imem_req), 0);
    check("mid_rst_pc", pc, 0);

    // Directed vector table.
    row(0,0,0,0,0,0,              0,0,0,0,0,0);
    row(1,0,0,0,1,0,              1,0,0,0,0,0);
    row(1,0,0,0,1,'h100,          1,1,1,1,'h100,1);
    row(1,0,0,0,1,'h101,          1,2,2,1,'h101,2);
    row(1,0,0,0,1,'h102,          1,3,3,1,'h102,3);
    row(1,0,0,0,1,'h103,          1,4,4,1,'h103,4);
    row(1,0,0,0,1,'h104,          1,5,5,1,'h104,5);
    row(1,0,0,1,1,'hAAAA,         0,5,5,1,'h104,5);
    row(1,0,0,1,1,0,              0,5,5,1,'h104,5);
    row(1,0,0,1,1,0,              0,5,5,1,'h104,5);
    row(1,0,0,0,1,0,              1,6,6,1,'hAAAA,6);
    row(1,0,0,0,1,'h106,          1,7,7,1,'h106,7);
    row(1,0,0,0,0,0,              1,7,7,0,0,7);
    row(1,0,0,0,0,0,              1,7,7,0,0,7);
    row(1,0,0,0,1,'h107,          1,8,8,1,'h107,8);
    row(1,0,0,0,0,0,              1,8,8,0,0,8);
    row(1,1,'h40,0,0,0,           1,8,'h40,0,0,8);
    row(1,1,'h80,0,0,0,           1,8,'h80,0,0,8);
    row(1,0,0,0,1,'hDEAD,         1,'h80,'h80,0,0,8);
    row(1,0,0,0,1,'h180,          1,'h81,'h81,1,'h180,'h81);
    row(1,1,'h200,1,1,'h181,      1,'h200,'h200,0,0,'h81);
    row(1,0,0,0,1,'h300,          1,'h201,'h201,1,'h300,'h201);
    row(1,1,'hFFFFFFFF,0,1,'h301,
        1,'hFFFFFFFF,'hFFFFFFFF,0,0,'h201);
    row(1,0,0,0,1,'h55,           1,0,0,1,'h55,0);
    row(1,0,0,1,1,'h66,           0,0,0,1,'h55,0);
    row(1,1,'h10,1,0,0,           1,'h10,'h10,0,0,0);
    row(1,0,0,0,1,'h77,           1,'h11,'h11,1,'h77,'h11);

    foreach (vq[k]) begin
      drive(vq[k].rst_n, vq[k].pcsrc, vq[k].tgt,
            vq[k].stall, vq[k].ack, vq[k].rdata);
      tick();
      check($sformatf("v%0d_req", k), 32'(imem_req),
            32'(vq[k].req));
      check($sformatf("v%0d_addr", k), imem_addr, vq[k].addr);
      check($sformatf("v%0d_pc", k), pc, vq[k].pc);
      check($sformatf("v%0d_valid", k), 32'(if_id_valid),
            32'(vq[k].valid));
      check($sformatf("v%0d_instr", k), if_id_instr, vq[k].instr);
      check($sformatf("v%0d_npc", k), if_id_npc, vq[k].npc);
      check($sformatf("v%0d_err", k), 32'(timeout_err), 0);
    end

    // Random run against the reference model.
    drive(0, 0, 0, 0, 0, 0);
    model_step(0, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic        r, ps, st, ak;
      logic [31:0] tg, rd;
      check("rnd_req", 32'(imem_req), 32'(m_busy));
      check("rnd_addr", imem_addr, m_addr);
      check("rnd_pc", pc, m_pc);
      check("rnd_valid", 32'(if_id_valid), 32'(m_valid));
      check("rnd_instr", if_id_instr, m_instr);
      check("rnd_npc", if_id_npc, m_npc);
      check("rnd_err", 32'(timeout_err), 32'(m_err));
      r  = ($urandom_range(0, 149) != 0);
      ps = ($urandom_range(0, 11) == 0);
      tg = ($urandom_range(0, 3) == 0)
             ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
             : $urandom;
      st = ($urandom_range(0, 3) == 0);
      ak = m_busy && ($urandom_range(0, 1) == 1);
      rd = $urandom;
      drive(r, ps, tg, st, ak, rd);
      model_step(r, ps, tg, st, ak, rd);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
